// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-policy car sequencer. Latches floor requests,
// picks a travel direction, steps the car one floor per travel period and
// holds the door open for a dwell period at every served floor.
module elevator_scheduler #(
  parameter  int FLOORS        = 5,
  parameter  int TRAVEL_CYCLES = 4,
  parameter  int DOOR_CYCLES   = 3,
  localparam int FW            = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] request_floors,
  input  logic              door_hold,
  output logic [FW-1:0]     current_floor,
  output logic              moving_up,
  output logic              moving_down,
  output logic              door_open,
  output logic              arrived,
  output logic [FLOORS-1:0] pending
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(FLOORS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              dir_reg, dir_next;          // 1 = up
  logic [FW-1:0]     floor_reg, floor_next;
  logic [FLOORS-1:0] pending_reg, pending_next;
  logic [TW-1:0]     travel_reg, travel_next;
  logic [DW-1:0]     dwell_reg, dwell_next;
  logic              arrived_reg, arrived_next;

  logic [FLOORS-1:0] next_req;
  logic              above, below, here;
  logic [FW-1:0]     step_floor;

  // True when any request lies strictly beyond flr in the given direction.
  function automatic logic req_beyond(input logic [FLOORS-1:0] req,
                                      input logic [FW-1:0]     flr,
                                      input logic              up);
    logic found;
    found = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (up ? (FW'(i) > flr) : (FW'(i) < flr)) found = found | req[i];
    end
    return found;
  endfunction

  // Requests sampled this edge take part in this edge's decisions.
  always_comb begin
    next_req = pending_reg | request_floors;
    above    = req_beyond(next_req, floor_reg, 1'b1);
    below    = req_beyond(next_req, floor_reg, 1'b0);
    here     = next_req[floor_reg];
  end

  // Next-state, counter and request-bitmap logic.
  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    floor_next   = floor_reg;
    pending_next = next_req;
    travel_next  = travel_reg;
    dwell_next   = dwell_reg;
    arrived_next = 1'b0;
    step_floor   = floor_reg;

    case (state_reg)
      ST_IDLE: begin
        if (here) begin
          state_next              = ST_DOOR;
          pending_next[floor_reg] = 1'b0;
          dwell_next              = DOOR_LOAD;
          arrived_next            = 1'b1;
        end else if ((dir_reg && above) || (!dir_reg && below)) begin
          state_next  = ST_MOVE;
          travel_next = TRAVEL_LOAD;
        end else if (above) begin
          state_next  = ST_MOVE;
          dir_next    = 1'b1;
          travel_next = TRAVEL_LOAD;
        end else if (below) begin
          state_next  = ST_MOVE;
          dir_next    = 1'b0;
          travel_next = TRAVEL_LOAD;
        end
      end

      ST_MOVE: begin
        if (travel_reg == '0) begin
          // Stepping is gated at the end floors so the car can never leave range.
          if (dir_reg && floor_reg != TOP_FLOOR)
            step_floor = floor_reg + 1'b1;
          else if (!dir_reg && floor_reg != '0)
            step_floor = floor_reg - 1'b1;
          floor_next = step_floor;
          if (next_req[step_floor]) begin
            state_next               = ST_DOOR;
            pending_next[step_floor] = 1'b0;
            dwell_next               = DOOR_LOAD;
            arrived_next             = 1'b1;
          end else if (req_beyond(next_req, step_floor, dir_reg)) begin
            travel_next = TRAVEL_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          travel_next = travel_reg - 1'b1;
        end
      end

      ST_DOOR: begin
        // The open floor absorbs its own requests; they keep the door open.
        pending_next[floor_reg] = 1'b0;
        if (door_hold || request_floors[floor_reg])
          dwell_next = DOOR_LOAD;
        else if (dwell_reg == '0)
          state_next = ST_IDLE;
        else
          dwell_next = dwell_reg - 1'b1;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards all requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      dir_reg     <= 1'b1;
      floor_reg   <= '0;
      pending_reg <= '0;
      travel_reg  <= '0;
      dwell_reg   <= '0;
      arrived_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      floor_reg   <= floor_next;
      pending_reg <= pending_next;
      travel_reg  <= travel_next;
      dwell_reg   <= dwell_next;
      arrived_reg <= arrived_next;
    end
  end

  assign current_floor = floor_reg;
  assign moving_up     = (state_reg == ST_MOVE) && dir_reg;
  assign moving_down   = (state_reg == ST_MOVE) && !dir_reg;
  assign door_open     = (state_reg == ST_DOOR);
  assign arrived       = arrived_reg;
  assign pending       = pending_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios with hand-computed expectations.
module tb_elevator_scheduler;

  logic       clk;
  logic       rst;
  logic [4:0] request_floors;
  logic       door_hold;
  logic [2:0] current_floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic       arrived;
  logic [4:0] pending;

  int tests_run;
  int tests_failed;

  elevator_scheduler #(
    .FLOORS(5),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .request_floors(request_floors),
    .door_hold(door_hold),
    .current_floor(current_floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .arrived(arrived),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks every output of the car in one call.
  task automatic chk_all(input string tag, input int flr, input int up, input int dn,
                         input int door, input int arr, input int pend);
    chk({tag, ".floor"},   int'(current_floor), flr);
    chk({tag, ".up"},      int'(moving_up),     up);
    chk({tag, ".down"},    int'(moving_down),   dn);
    chk({tag, ".door"},    int'(door_open),     door);
    chk({tag, ".arrived"}, int'(arrived),       arr);
    chk({tag, ".pending"}, int'(pending),       pend);
  endtask

  task automatic pulse_req(input logic [4:0] r);
    request_floors = r;
    tick(1);
    request_floors = 5'b00000;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    request_floors = 5'b00000;
    door_hold      = 1'b0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    #10;
    rst = 1'b0;
    tick(1);
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    // Single request to floor 2 from floor 0.
    pulse_req(5'b00100);                        // edge 0
    chk_all("s1.e0", 0, 1, 0, 0, 0, 5'b00100);
    tick(3);                                    // edge 3
    chk_all("s1.e3", 0, 1, 0, 0, 0, 5'b00100);
    tick(1);                                    // edge 4
    chk_all("s1.e4", 1, 1, 0, 0, 0, 5'b00100);
    tick(4);                                    // edge 8
    chk_all("s1.e8", 2, 0, 0, 1, 1, 0);
    tick(1);
    chk_all("s1.e9", 2, 0, 0, 1, 0, 0);
    tick(1);
    chk_all("s1.e10", 2, 0, 0, 1, 0, 0);
    tick(1);
    chk_all("s1.e11", 2, 0, 0, 0, 0, 0);

    // At 2, dir up, requests above and below together: 4 first, then 0.
    pulse_req(5'b10001);                        // edge 0
    chk_all("s5.e0", 2, 1, 0, 0, 0, 5'b10001);
    tick(4);                                    // edge 4: floor 3, passes
    chk_all("s5.e4", 3, 1, 0, 0, 0, 5'b10001);
    tick(4);                                    // edge 8: floor 4 door
    chk_all("s5.e8", 4, 0, 0, 1, 1, 5'b00001);
    tick(3);                                    // edge 11: idle
    chk_all("s5.e11", 4, 0, 0, 0, 0, 5'b00001);
    tick(1);                                    // edge 12: move down
    chk_all("s5.e12", 4, 0, 1, 0, 0, 5'b00001);
    tick(12);                                   // edge 24: floor 1
    chk_all("s5.e24", 1, 0, 1, 0, 0, 5'b00001);
    tick(4);                                    // edge 28: floor 0 door
    chk_all("s5.e28", 0, 0, 0, 1, 1, 0);
    tick(3);
    chk_all("s5.e31", 0, 0, 0, 0, 0, 0);

    // Request for the current floor while idle: door next edge, no motion.
    pulse_req(5'b00001);
    chk_all("s2.e0", 0, 0, 0, 1, 1, 0);
    tick(2);
    chk_all("s2.e2", 0, 0, 0, 1, 0, 0);
    tick(1);
    chk_all("s2.e3", 0, 0, 0, 0, 0, 0);

    // door_hold held 5 cycles keeps the door open; drops 3 cycles after release.
    pulse_req(5'b00001);
    door_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("hold.open", int'(door_open), 1);
    end
    door_hold = 1'b0;
    tick(2);
    chk_all("hold.r2", 0, 0, 0, 1, 0, 0);
    tick(1);
    chk_all("hold.r3", 0, 0, 0, 0, 0, 0);

    // Re-request of the open floor restarts the dwell.
    pulse_req(5'b00001);                        // door entered
    tick(1);                                    // dwell 1
    pulse_req(5'b00001);                        // reload to 2
    chk_all("rereq.e2", 0, 0, 0, 1, 0, 0);
    tick(2);
    chk_all("rereq.e4", 0, 0, 0, 1, 0, 0);
    tick(1);
    chk_all("rereq.e5", 0, 0, 0, 0, 0, 0);

    // Travel 0 -> 4 with requests for 1 and 3 added en route (1 is behind).
    pulse_req(5'b10000);                        // edge 0
    tick(4);                                    // edge 5 after loop below
    chk_all("s3.e4", 1, 1, 0, 0, 0, 5'b10000);
    pulse_req(5'b01010);                        // edge 5
    chk_all("s3.e5", 1, 1, 0, 0, 0, 5'b11010);
    tick(3);                                    // edge 8: floor 2 passes
    chk_all("s3.e8", 2, 1, 0, 0, 0, 5'b11010);
    tick(4);                                    // edge 12: stop at 3
    chk_all("s3.e12", 3, 0, 0, 1, 1, 5'b10010);
    tick(4);                                    // edge 16: moving up again
    chk_all("s3.e16", 3, 1, 0, 0, 0, 5'b10010);
    tick(4);                                    // edge 20: stop at 4
    chk_all("s3.e20", 4, 0, 0, 1, 1, 5'b00010);
    tick(4);                                    // edge 24: reverse
    chk_all("s3.e24", 4, 0, 1, 0, 0, 5'b00010);
    tick(4);                                    // edge 28: floor 3 passes
    chk_all("s3.e28", 3, 0, 1, 0, 0, 5'b00010);
    tick(8);                                    // edge 36: stop at 1
    chk_all("s3.e36", 1, 0, 0, 1, 1, 0);
    tick(3);
    chk_all("s3.e39", 1, 0, 0, 0, 0, 0);

    // Request sampled on the same edge the car steps onto that floor.
    pulse_req(5'b10000);                        // edge 0, dir turns up
    chk_all("same.e0", 1, 1, 0, 0, 0, 5'b10000);
    tick(6);                                    // edge 6 (floor 2 at edge 4)
    chk_all("same.e6", 2, 1, 0, 0, 0, 5'b10000);
    tick(1);                                    // edge 7
    pulse_req(5'b01000);                        // edge 8: floor 3
    chk_all("same.e8", 3, 0, 0, 1, 1, 5'b10000);
    tick(8);                                    // edge 16: floor 4
    chk_all("same.e16", 4, 0, 0, 1, 1, 0);
    tick(3);
    chk_all("same.e19", 4, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a move.
    pulse_req(5'b00001);
    tick(5);                                    // floor 3, moving down
    chk_all("rmid.pre", 3, 0, 1, 0, 0, 5'b00001);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rmid.rst", 0, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b0;
    tick(10);
    chk_all("rmid.idle", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Sequencing controller for the elevator car: accumulates floor requests, decides travel direction with a SCAN (continue-in-direction) policy, steps the car floor-by-floor on a travel timer, and holds the door open on a dwell timer at each served floor. Sits between the request buttons (`request_floors`) and the motor/door drivers; it is the single owner of `current_floor` and of the pending-request bitmap.

## Interface
- `FLOORS`, 5, number of floors; floors numbered 0..FLOORS-1.
- `TRAVEL_CYCLES`, 4, clock cycles per one-floor move (≥1).
- `DOOR_CYCLES`, 3, clock cycles the door stays open per stop (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `request_floors`  in  FLOORS  request bits, one per floor; any high bit is a request, level or pulse.
- `door_hold`  in  1  restarts the door dwell timer while high in DOOR.
- `current_floor`  out  FW = max(1, $clog2(FLOORS))  floor the car is at.
- `moving_up`  out  1  motor up drive; high exactly while in MOVE with dir = up.
- `moving_down`  out  1  motor down drive; high exactly while in MOVE with dir = down.
- `door_open`  out  1  high exactly while in DOOR.
- `arrived`  out  1  one-cycle pulse in the first DOOR cycle of every stop.
- `pending`  out  FLOORS  registered outstanding-request bitmap.

## Operation
- `next_req = pending | request_floors`; every decision below uses `next_req`, so a request sampled on an edge acts on that same edge.
- Registered `dir` (1 = up). `above` = any `next_req` bit > current_floor; `below` = any bit < current_floor; `here` = `next_req[current_floor]`.
- States IDLE, MOVE, DOOR.
- IDLE: `here` → DOOR (floor bit cleared, dwell loaded). Else if (`dir` up and `above`) or (`dir` down and `below`) → MOVE same dir. Else if `above` → dir:=up, MOVE. Else if `below` → dir:=down, MOVE. Else stay.
- MOVE: travel counter loaded with TRAVEL_CYCLES-1 on entry; decrements each cycle; on a cycle where it is 0, current_floor steps ±1 per dir. On that same edge: if `next_req[new floor]` → DOOR; else if requests remain beyond new floor in dir → stay MOVE, reload counter; else → IDLE.
- DOOR: dwell counter loaded with DOOR_CYCLES-1 on entry; `pending[current_floor]` forced 0 every cycle (requests for the open floor are absorbed and also reload the dwell counter, as does `door_hold`). Counter 0 with no reload → IDLE.
- Pending bits set by `request_floors` are cleared only when that floor is served in DOOR.
- current_floor never leaves 0..FLOORS-1: MOVE is entered only toward a pending bit, and stepping is gated at the end floors.
- Requests at intermediate floors in the travel direction are served on the way (car stops there); requests behind the car wait for reversal.

## Timing
- Reset (async, immediate, no clock needed): state IDLE, dir up, current_floor 0, pending 0, counters 0, all outputs 0.
- Reset mid-MOVE or mid-DOOR: same values; all requests discarded.
- IDLE → MOVE on the request edge k; current_floor changes at edge k+TRAVEL_CYCLES, and at every subsequent TRAVEL_CYCLES edges while moving.
- Stop: DOOR entered on the floor-change edge; door_open high for exactly DOOR_CYCLES cycles absent reloads; arrived high in the first of them.
- Request for current floor while IDLE: DOOR on the next edge; pending bit never observed set.
- Request sampled on the same edge as a floor step to that floor: car stops there.
- Simultaneous above and below requests in IDLE: current dir wins.
- Throughput: one floor per TRAVEL_CYCLES; no extra bubble between consecutive floors or between DOOR expiry and next MOVE beyond one IDLE cycle.

## Test plan
- Reset, pulse request_floors=00100 at edge 0 → moving_up 1 from edge 0, current_floor 1 at edge 4, 2 at edge 8; door_open cycles 8–10, arrived at cycle 8, pending 00000, IDLE at edge 11.
- At floor 0 IDLE, request 00001 → door_open 3 cycles starting next edge, no motion, pending stays 00000.
- Car at 2 moving up to 4; during travel request 00010 and 01000 → stops at 3 then 4, then dir down, travels to 1 and stops; pending 00000 at end.
- In DOOR, hold door_hold 5 cycles → door_open stays high throughout, drops 3 cycles after release; re-request of current floor likewise restarts dwell.
- Car IDLE at 2, dir up, request 10001 in one cycle → serves 4 first, then 0; never reverses early.
- Assert rst mid-MOVE between clock edges → current_floor 0, all outputs 0 immediately; after release, no motion until a new request.
